// File: rtl/sm_pkg.sv
// ---------------------------------------------------------------------------
// sm_pkg
// Shared definitions for the SFU arbitration slice.
//   sfu_arb_state_t : operation state of sfu_arbiter (IDLE/ISSUE/WAIT/RESP)
//   DEFAULT_DATA_W  : default operand/result width
//   idx_width()     : index width for a count of items, never below one bit
// ---------------------------------------------------------------------------
package sm_pkg;

    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sfu_arb_state_t;

    // A single item still needs a one-bit index so that ports never collapse
    // to zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin grant selection: picks the first set bit
// of req at or after ptr, wrapping from NUM_REQ-1 back to 0.
// Ports:
//   req       in   NUM_REQ  request vector
//   ptr       in   IDX_W    position searched first
//   grant     out  NUM_REQ  one-hot grant (all zero when req is empty)
//   grant_idx out  IDX_W    index of the granted bit (0 when req is empty)
// ---------------------------------------------------------------------------
module rr_arbiter
    import sm_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Walk the requesters starting at the pointer position and stop at the
    // first active one. The walk order, not the bit position, decides the
    // winner, which is what gives every requester its turn.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found           = 1'b1;
                grant[cand]     = 1'b1;
                grant_idx       = cand;
            end
        end
    end

endmodule

// File: rtl/sfu_arbiter.sv
// ---------------------------------------------------------------------------
// sfu_arbiter
// Shares one special-function unit between NUM_REQ requesters. One operation
// is in flight at a time: a request is accepted in IDLE, started on the SFU in
// ISSUE, its result awaited in WAIT (bounded by TIMEOUT cycles) and handed
// back to the owning requester in RESP. Fairness comes from a round-robin
// pointer that moves past the owner only when its response is taken.
// Ports:
//   clk, rst_n   clock; asynchronous active-low reset
//   req_valid    in   NUM_REQ         per-requester operation request
//   req_data     in   NUM_REQ*DATA_W  operands, requester k at [k*DATA_W +: DATA_W]
//   req_ready    out  NUM_REQ         one-hot accept strobe (IDLE only)
//   resp_valid   out  NUM_REQ         one-hot result valid to the owner
//   resp_data    out  DATA_W          result (zero after a timeout)
//   resp_err     out  1               result was produced by a timeout
//   resp_ready   in   NUM_REQ         per-requester result accept
//   sfu_start    out  1               one-cycle start pulse to the SFU
//   sfu_in       out  DATA_W          operand to the SFU
//   sfu_out      in   DATA_W          SFU result
//   sfu_ready    in   1               SFU result-valid pulse
//   busy         out  1               high whenever not IDLE
// ---------------------------------------------------------------------------
module sfu_arbiter
    import sm_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_data,
    output logic                      resp_err,
    input  logic [NUM_REQ-1:0]        resp_ready,
    output logic                      sfu_start,
    output logic [DATA_W-1:0]         sfu_in,
    input  logic [DATA_W-1:0]         sfu_out,
    input  logic                      sfu_ready,
    output logic                      busy
);

    localparam int               IDX_W    = idx_width(NUM_REQ);
    localparam int               CNT_W    = idx_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    sfu_arb_state_t   state;
    sfu_arb_state_t   state_nxt;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] owner;
    logic [CNT_W-1:0] count;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             accept;
    logic             sfu_done;
    logic             timed_out;
    logic             resp_taken;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Next-state and output decode. Every strobe defaults low so that only
    // the active state drives anything. req_ready is additionally qualified
    // by rst_n because the register state already reads IDLE while reset is
    // held, and no requester may see an accept during reset. A result pulse
    // wins over an expiring timeout in the same cycle.
    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        resp_valid = '0;
        sfu_start  = 1'b0;
        busy       = (state != IDLE);
        accept     = 1'b0;
        sfu_done   = 1'b0;
        timed_out  = 1'b0;
        resp_taken = 1'b0;
        case (state)
            IDLE: begin
                if (rst_n && (|req_valid)) begin
                    accept    = 1'b1;
                    req_ready = grant;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                sfu_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (sfu_ready) begin
                    sfu_done  = 1'b1;
                    state_nxt = RESP;
                end else if (count == CNT_LAST) begin
                    timed_out = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid[owner] = 1'b1;
                resp_taken        = resp_ready[owner];
                if (resp_taken) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register and datapath. The operand and owner are captured on
    // accept and held until the next accept, so sfu_in stays stable through
    // WAIT. The result registers only change on leaving WAIT, which keeps
    // resp_data/resp_err steady for however long RESP is back-pressured.
    // Reset discards any in-flight operation; a late sfu_ready then lands in
    // IDLE and is ignored. The pointer moves only when a response is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            count     <= '0;
            sfu_in    <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner  <= grant_idx;
                sfu_in <= req_data[int'(grant_idx)*DATA_W +: DATA_W];
            end
            if (state == ISSUE) begin
                count <= '0;
            end
            if (sfu_done) begin
                resp_data <= sfu_out;
                resp_err  <= 1'b0;
            end else if (timed_out) begin
                resp_data <= '0;
                resp_err  <= 1'b1;
            end else if (state == WAIT) begin
                count <= count + 1'b1;
            end
            if (resp_taken) begin
                rr_ptr <= (owner == IDX_LAST) ? '0 : owner + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sfu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sfu_arbiter
// Self-checking bench for sfu_arbiter. A behavioural SFU stub answers each
// start after a chosen latency (or never). The reference model works at the
// transaction level: on accept it predicts the owner from the round-robin
// rule and the full response timeline (start one cycle later, result
// latency+2 cycles after accept, or a timeout result TIMEOUT+2 cycles after).
// ---------------------------------------------------------------------------
module tb_sfu_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = sm_pkg::DEFAULT_DATA_W;
    localparam int TIMEOUT = 16;
    localparam int IW      = $clog2(NUM_REQ);

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [DATA_W-1:0]         resp_data;
    logic                      resp_err;
    logic [NUM_REQ-1:0]        resp_ready = '0;
    logic                      sfu_start;
    logic [DATA_W-1:0]         sfu_in;
    logic [DATA_W-1:0]         sfu_out = '0;
    logic                      sfu_ready = 1'b0;
    logic                      busy;

    sfu_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .resp_ready (resp_ready),
        .sfu_start  (sfu_start),
        .sfu_in     (sfu_in),
        .sfu_out    (sfu_out),
        .sfu_ready  (sfu_ready),
        .busy       (busy)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [NUM_REQ-1:0] stim_valid  = '0;
    logic [NUM_REQ-1:0] stim_rready = '1;
    logic [DATA_W-1:0]  stim_data [NUM_REQ];
    int                 next_lat = 1;
    bit                 stray_en = 1'b0;

    bit                 fire_armed = 1'b0;
    int                 fire_cycle = 0;
    logic [DATA_W-1:0]  fire_val   = '0;
    int                 stub_lat   = 1;

    bit                 m_busy     = 1'b0;
    int                 m_ptr      = 0;
    int                 m_owner    = 0;
    int                 m_acc      = 0;
    int                 m_resp_cyc = 0;
    logic [DATA_W-1:0]  m_operand  = '0;
    logic [DATA_W-1:0]  m_data     = '0;
    logic               m_err      = 1'b0;

    bit                 log_en = 1'b0;
    int                 log_owner [$];
    int                 log_cyc   [$];
    bit                 bp_en  = 1'b0;
    int                 rv1_cnt = 0;
    int                 last_grant_cyc = 0;
    int                 last_grant_idx = 0;
    int                 last_start_cyc = 0;
    int                 first_rv_cyc   = -1;
    logic [DATA_W-1:0]  first_rv_data  = '0;
    logic               first_rv_err   = 1'b0;
    int                 pick;

    function automatic logic [DATA_W-1:0] sfuFunc(input logic [DATA_W-1:0] x);
        return {x[15:0], x[31:16]} ^ 32'h5A5A_0FF0;
    endfunction

    function automatic logic [NUM_REQ-1:0] oneHot(input int i);
        return NUM_REQ'(1) << i;
    endfunction

    function automatic int firstFrom(input logic [NUM_REQ-1:0] v, input int p);
        int j;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (p + k) % NUM_REQ;
            if (v[j[IW-1:0]]) return j;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s @cycle %0d: observed %0h required %0h", tag, cyc, obs, exp);
        end
    endtask

    // Drives all DUT inputs for the current cycle, including the SFU stub:
    // a scheduled result pulse, or (when enabled) a stray pulse that must be
    // ignored because the model says no operation is waiting for a result.
    task automatic applyStimulus();
        bit in_wait;
        req_valid  = stim_valid;
        resp_ready = stim_rready;
        for (int k = 0; k < NUM_REQ; k++) req_data[k*DATA_W +: DATA_W] = stim_data[k];
        in_wait   = m_busy && (cyc >= m_acc + 2) && (cyc < m_resp_cyc);
        sfu_ready = 1'b0;
        sfu_out   = $urandom;
        if (fire_armed && cyc == fire_cycle) begin
            sfu_ready  = 1'b1;
            sfu_out    = fire_val;
            fire_armed = 1'b0;
        end else if (stray_en && !in_wait && $urandom_range(3) == 0) begin
            sfu_ready = 1'b1;
        end
    endtask

    task automatic modelAccept(input int g);
        m_busy    = 1'b1;
        m_owner   = g;
        m_acc     = cyc;
        m_operand = stim_data[g];
        stub_lat  = next_lat;
        if (next_lat != 0 && next_lat <= TIMEOUT) begin
            m_resp_cyc = cyc + 2 + next_lat;
            m_data     = sfuFunc(m_operand);
            m_err      = 1'b0;
        end else begin
            m_resp_cyc = cyc + 2 + TIMEOUT;
            m_data     = '0;
            m_err      = 1'b1;
        end
    endtask

    task automatic runCycle();
        logic [NUM_REQ-1:0] exp_rdy;
        logic [NUM_REQ-1:0] exp_rv;
        bit resp_phase;
        int g;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus();
        #1;
        resp_phase = m_busy && (cyc >= m_resp_cyc);
        g          = firstFrom(stim_valid, m_ptr);
        exp_rdy    = (!m_busy && g >= 0) ? oneHot(g) : '0;
        exp_rv     = resp_phase ? oneHot(m_owner) : '0;
        checkOutput("req_ready", req_ready, exp_rdy);
        checkOutput("resp_valid", resp_valid, exp_rv);
        checkOutput("busy", busy, m_busy);
        checkOutput("sfu_start", sfu_start, m_busy && (cyc == m_acc + 1));
        if (m_busy && !resp_phase) checkOutput("sfu_in", sfu_in, m_operand);
        if (resp_phase) begin
            checkOutput("resp_data", resp_data, m_data);
            checkOutput("resp_err", resp_err, m_err);
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_ready[k]) begin
                last_grant_cyc = cyc;
                last_grant_idx = k;
                first_rv_cyc   = -1;
                if (log_en) begin
                    log_owner.push_back(k);
                    log_cyc.push_back(cyc);
                end
            end
        end
        if (sfu_start) begin
            last_start_cyc = cyc;
            fire_armed     = (stub_lat != 0);
            fire_cycle     = cyc + stub_lat;
            fire_val       = sfuFunc(sfu_in);
        end
        if ((|resp_valid) && first_rv_cyc < 0) begin
            first_rv_cyc  = cyc;
            first_rv_data = resp_data;
            first_rv_err  = resp_err;
        end
        if (bp_en && resp_valid[1]) rv1_cnt++;
        if (!m_busy) begin
            if (g >= 0) modelAccept(g);
        end else if (resp_phase && stim_rready[m_owner[IW-1:0]]) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % NUM_REQ;
        end
        cyc++;
    endtask

    task automatic resetCycle();
        @(negedge clk);
        applyStimulus();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_req_ready", req_ready, '0);
        checkOutput("rst_resp_valid", resp_valid, '0);
        checkOutput("rst_sfu_start", sfu_start, '0);
        checkOutput("rst_busy", busy, '0);
        checkOutput("rst_resp_data", resp_data, '0);
        checkOutput("rst_resp_err", resp_err, '0);
        checkOutput("rst_sfu_in", sfu_in, '0);
        m_busy = 1'b0;
        m_ptr  = 0;
        cyc++;
    endtask

    // Hard bound on run time in case the main sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by a randomized phase, all checked against
    // the transaction-level model on every cycle.
    initial begin
        for (int k = 0; k < NUM_REQ; k++) stim_data[k] = '0;
        resetCycle();
        resetCycle();

        $display("[TB] single request from requester 2");
        stim_valid   = 4'b0100;
        stim_data[2] = 32'h4000_0000;
        next_lat     = 1;
        runCycle();
        stim_valid = '0;
        repeat (5) runCycle();
        checkOutput("single_grant_idx", last_grant_idx, 2);
        checkOutput("single_start_lat", last_start_cyc - last_grant_cyc, 1);
        checkOutput("single_resp_lat", first_rv_cyc - last_grant_cyc, 3);
        checkOutput("single_resp_data", first_rv_data, sfuFunc(32'h4000_0000));
        checkOutput("single_resp_err", first_rv_err, 1'b0);

        $display("[TB] backpressure on requester 1");
        stim_valid   = 4'b0010;
        stim_data[1] = $urandom;
        stim_data[3] = $urandom;
        runCycle();
        stim_valid = 4'b1010;
        bp_en      = 1'b1;
        rv1_cnt    = 0;
        for (int n = 0; n < 10; n++) begin
            stim_rready = (m_busy && m_owner == 1 && cyc < m_resp_cyc + 5) ? 4'b1101 : 4'b1111;
            runCycle();
        end
        bp_en       = 1'b0;
        stim_valid  = '0;
        stim_rready = '1;
        repeat (6) runCycle();
        checkOutput("bp_hold_cycles", rv1_cnt, 6);

        $display("[TB] timeout with a silent SFU");
        pick             = $urandom_range(NUM_REQ - 1);
        stim_valid       = oneHot(pick);
        stim_data[pick]  = $urandom;
        next_lat         = 0;
        runCycle();
        stim_valid = '0;
        repeat (19) runCycle();
        checkOutput("timeout_resp_lat", first_rv_cyc - last_grant_cyc, TIMEOUT + 2);
        checkOutput("timeout_resp_data", first_rv_data, '0);
        checkOutput("timeout_resp_err", first_rv_err, 1'b1);

        $display("[TB] result on the expiry cycle");
        pick             = $urandom_range(NUM_REQ - 1);
        stim_valid       = oneHot(pick);
        stim_data[pick]  = $urandom;
        next_lat         = TIMEOUT;
        runCycle();
        stim_valid = '0;
        repeat (19) runCycle();
        checkOutput("expiry_resp_lat", first_rv_cyc - last_grant_cyc, TIMEOUT + 2);
        checkOutput("expiry_resp_err", first_rv_err, 1'b0);
        checkOutput("expiry_resp_data", first_rv_data, sfuFunc(stim_data[pick]));

        $display("[TB] reset while waiting on the SFU");
        stim_valid   = 4'b0100;
        stim_data[2] = $urandom;
        next_lat     = 3;
        runCycle();
        stim_valid = '0;
        repeat (2) runCycle();
        stim_valid = 4'b1111;
        next_lat   = 1;
        log_en     = 1'b1;
        resetCycle();

        $display("[TB] fairness with all requesters active");
        for (int n = 0; n < 24; n++) begin
            for (int k = 0; k < NUM_REQ; k++) stim_data[k] = $urandom;
            runCycle();
        end
        log_en = 1'b0;
        checkOutput("fair_grant_count", log_owner.size() >= 6, 1'b1);
        if (log_owner.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                checkOutput("fair_order", log_owner[i], i % NUM_REQ);
                if (i > 0) checkOutput("fair_spacing", log_cyc[i] - log_cyc[i-1], 4);
            end
        end
        stim_valid = '0;
        repeat (6) runCycle();

        $display("[TB] randomized traffic");
        stray_en = 1'b1;
        for (int n = 0; n < 500; n++) begin
            stim_valid  = NUM_REQ'($urandom);
            stim_rready = NUM_REQ'($urandom | $urandom);
            for (int k = 0; k < NUM_REQ; k++) stim_data[k] = $urandom;
            case ($urandom_range(7))
                0:       next_lat = 0;
                1:       next_lat = TIMEOUT + $urandom_range(2);
                default: next_lat = 1 + $urandom_range(TIMEOUT - 1);
            endcase
            if ($urandom_range(149) == 0) resetCycle();
            else                          runCycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
